// File: rtl/morse_encode_word.sv
// Serialises a word of character codes (top slot first) into an active-low Morse keying line.
// Timing comes from the latched dit/dah/word times. start is taken only when idle, and ce freezes everything.
module morse_encode_word #(
    parameter int CHAR_W      = 6,
    parameter int MAX_CHARS   = 6,
    parameter int PULSE_CNT_W = 26
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ce,
    input  logic                        start,
    input  logic [CHAR_W*MAX_CHARS-1:0] word,
    input  logic [PULSE_CNT_W-1:0]      dit_time,
    input  logic [PULSE_CNT_W-1:0]      dah_time,
    input  logic [PULSE_CNT_W-1:0]      word_time,
    output logic                        signal,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);

    localparam int IDX_W = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_MARK,
        S_EGAP,
        S_CGAP,
        S_WGAP,
        S_DONE
    } state_t;

    // Element bits are left-aligned: bit 4 is always the next element to send (1 = dah).
    typedef struct packed {
        logic       vld;
        logic [2:0] len;
        logic [4:0] bits;
    } pat_t;

    function automatic pat_t mk(input logic [2:0] len, input logic [4:0] rbits);
        pat_t p;
        p.vld  = 1'b1;
        p.len  = len;
        p.bits = rbits << (3'd5 - len);
        return p;
    endfunction

    function automatic pat_t lut(input logic [CHAR_W-1:0] c);
        pat_t p;
        p = '0;
        case (int'(c))
            1:  p = mk(3'd2, 5'b00001);
            2:  p = mk(3'd4, 5'b01000);
            3:  p = mk(3'd4, 5'b01010);
            4:  p = mk(3'd3, 5'b00100);
            5:  p = mk(3'd1, 5'b00000);
            6:  p = mk(3'd4, 5'b00010);
            7:  p = mk(3'd3, 5'b00110);
            8:  p = mk(3'd4, 5'b00000);
            9:  p = mk(3'd2, 5'b00000);
            10: p = mk(3'd4, 5'b00111);
            11: p = mk(3'd3, 5'b00101);
            12: p = mk(3'd4, 5'b00100);
            13: p = mk(3'd2, 5'b00011);
            14: p = mk(3'd2, 5'b00010);
            15: p = mk(3'd3, 5'b00111);
            16: p = mk(3'd4, 5'b00110);
            17: p = mk(3'd4, 5'b01101);
            18: p = mk(3'd3, 5'b00010);
            19: p = mk(3'd3, 5'b00000);
            20: p = mk(3'd1, 5'b00001);
            21: p = mk(3'd3, 5'b00001);
            22: p = mk(3'd4, 5'b00001);
            23: p = mk(3'd3, 5'b00011);
            24: p = mk(3'd4, 5'b01001);
            25: p = mk(3'd4, 5'b01011);
            26: p = mk(3'd4, 5'b01100);
            27: p = mk(3'd5, 5'b11111);
            28: p = mk(3'd5, 5'b01111);
            29: p = mk(3'd5, 5'b00111);
            30: p = mk(3'd5, 5'b00011);
            31: p = mk(3'd5, 5'b00001);
            32: p = mk(3'd5, 5'b00000);
            33: p = mk(3'd5, 5'b10000);
            34: p = mk(3'd5, 5'b11000);
            35: p = mk(3'd5, 5'b11100);
            36: p = mk(3'd5, 5'b11110);
            default: p = '0;
        endcase
        return p;
    endfunction

    function automatic logic [PULSE_CNT_W-1:0] tm1(input logic [PULSE_CNT_W-1:0] t);
        return (t == '0) ? '0 : t - PULSE_CNT_W'(1);
    endfunction

    state_t                        r_state;
    logic [PULSE_CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]              r_idx;
    logic [4:0]                    r_pat;
    logic [2:0]                    r_rem;
    logic [CHAR_W*MAX_CHARS-1:0]   r_word;
    logic [PULSE_CNT_W-1:0]        r_dit;
    logic [PULSE_CNT_W-1:0]        r_dah;
    logic [PULSE_CNT_W-1:0]        r_wt;
    logic                          r_signal;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_error;

    logic [CHAR_W-1:0]             w_cur_code;
    logic [CHAR_W-1:0]             w_nxt_code;
    logic                          w_low_nz;
    logic                          w_last;
    pat_t                          w_cur_pat;
    pat_t                          w_nxt_pat;
    logic                          w_nxt_bad;
    logic [PULSE_CNT_W-1:0]        w_dit_m1;
    logic [PULSE_CNT_W-1:0]        w_dah_m1;
    logic [PULSE_CNT_W-1:0]        w_wt_m1;

    // Current slot, the slot below it, and whether anything nonzero remains below.
    always_comb begin
        w_cur_code = '0;
        w_nxt_code = '0;
        w_low_nz   = 1'b0;
        for (int i = 0; i < MAX_CHARS; i++) begin
            if (r_idx == IDX_W'(i))
                w_cur_code = r_word[i*CHAR_W +: CHAR_W];
            if (r_idx == IDX_W'(i + 1))
                w_nxt_code = r_word[i*CHAR_W +: CHAR_W];
            if ((IDX_W'(i) < r_idx) && (r_word[i*CHAR_W +: CHAR_W] != '0))
                w_low_nz = 1'b1;
        end
    end

    // Trailing zero slots carry no timing; the word ends after the lowest nonzero slot.
    assign w_last    = (r_idx == '0) || !w_low_nz;
    assign w_cur_pat = lut(w_cur_code);
    assign w_nxt_pat = lut(w_nxt_code);
    assign w_nxt_bad = (w_nxt_code != '0) && !w_nxt_pat.vld;
    assign w_dit_m1  = tm1(r_dit);
    assign w_dah_m1  = tm1(r_dah);
    assign w_wt_m1   = tm1(r_wt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_pat    <= '0;
            r_rem    <= '0;
            r_word   <= '0;
            r_dit    <= '0;
            r_dah    <= '0;
            r_wt     <= '0;
            r_signal <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else if (ce) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_word  <= word;
                        r_dit   <= dit_time;
                        r_dah   <= dah_time;
                        r_wt    <= word_time;
                        r_idx   <= IDX_W'(MAX_CHARS - 1);
                        r_busy  <= 1'b1;
                        r_error <= 1'b0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_cur_pat.vld) begin
                        r_pat    <= w_cur_pat.bits;
                        r_rem    <= w_cur_pat.len;
                        r_cnt    <= w_cur_pat.bits[4] ? w_dah_m1 : w_dit_m1;
                        r_signal <= 1'b0;
                        r_state  <= S_MARK;
                    end else if ((w_cur_code != '0) || (r_idx == '0)) begin
                        r_error <= r_error | (w_cur_code != '0);
                        r_cnt   <= w_wt_m1;
                        r_state <= S_WGAP;
                    end else begin
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
                S_MARK: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - PULSE_CNT_W'(1);
                    end else begin
                        r_signal <= 1'b1;
                        if (r_rem > 3'd1) begin
                            r_pat   <= {r_pat[3:0], 1'b0};
                            r_rem   <= r_rem - 3'd1;
                            r_cnt   <= w_dit_m1;
                            r_state <= S_EGAP;
                        end else if (w_last) begin
                            r_cnt   <= w_wt_m1;
                            r_state <= S_WGAP;
                        end else if (w_nxt_pat.vld) begin
                            // Next character is fetched here so CGAP hands straight over to MARK.
                            r_idx   <= r_idx - IDX_W'(1);
                            r_pat   <= w_nxt_pat.bits;
                            r_rem   <= w_nxt_pat.len;
                            r_cnt   <= w_dah_m1;
                            r_state <= S_CGAP;
                        end else begin
                            r_idx   <= r_idx - IDX_W'(1);
                            r_error <= r_error | w_nxt_bad;
                            r_cnt   <= w_wt_m1;
                            r_state <= S_WGAP;
                        end
                    end
                end
                S_EGAP, S_CGAP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - PULSE_CNT_W'(1);
                    end else begin
                        r_cnt    <= r_pat[4] ? w_dah_m1 : w_dit_m1;
                        r_signal <= 1'b0;
                        r_state  <= S_MARK;
                    end
                end
                S_WGAP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - PULSE_CNT_W'(1);
                    end else if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_nxt_pat.vld) begin
                        r_idx    <= r_idx - IDX_W'(1);
                        r_pat    <= w_nxt_pat.bits;
                        r_rem    <= w_nxt_pat.len;
                        r_cnt    <= w_nxt_pat.bits[4] ? w_dah_m1 : w_dit_m1;
                        r_signal <= 1'b0;
                        r_state  <= S_MARK;
                    end else begin
                        r_idx   <= r_idx - IDX_W'(1);
                        r_error <= r_error | w_nxt_bad;
                        r_cnt   <= w_wt_m1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign signal = r_signal;
    assign busy   = r_busy;
    assign done   = r_done;
    assign error  = r_error;

endmodule

// File: tb/tb_morse_encode_word.sv
// Randomised and directed bench for morse_encode_word with a queue-based scoreboard.
// Expected keying run-lengths come from a dot/dash string model of each word.
module tb_morse_encode_word;

    localparam int CW = 6;
    localparam int MC = 6;
    localparam int PW = 26;

    logic             clk;
    logic             rst_n;
    logic             ce;
    logic             start;
    logic [CW*MC-1:0] word;
    logic [PW-1:0]    dit_time;
    logic [PW-1:0]    dah_time;
    logic [PW-1:0]    word_time;
    logic             signal;
    logic             busy;
    logic             done;
    logic             error;

    int    n_chk;
    int    n_fail;
    int    n_issued;
    int    txn_seen;
    bit    ce_toggle;
    string tbl[37];
    int    exp_runs[$];
    int    exp_nruns[$];
    bit    exp_err[$];

    morse_encode_word #(.CHAR_W(CW), .MAX_CHARS(MC), .PULSE_CNT_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .start(start), .word(word),
        .dit_time(dit_time), .dah_time(dah_time), .word_time(word_time),
        .signal(signal), .busy(busy), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        ce = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ce = ce_toggle ? ~ce : 1'b1;
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [CW*MC-1:0] mkw(input int s5, input int s4, input int s3,
                                               input int s2, input int s1, input int s0);
        logic [CW*MC-1:0] w;
        w = {CW'(s5), CW'(s4), CW'(s3), CW'(s2), CW'(s1), CW'(s0)};
        return w;
    endfunction

    // Reference: lay out the line level per effective cycle, then run-length encode it.
    function automatic void model(input logic [CW*MC-1:0] w, input int dit_i, input int dah_i, input int wt_i);
        bit    lv[$];
        int    dit, dah, wt, hi, lo, c, run, nr;
        bit    err, prev_char;
        string s;
        dit = (dit_i == 0) ? 1 : dit_i;
        dah = (dah_i == 0) ? 1 : dah_i;
        wt  = (wt_i == 0) ? 1 : wt_i;
        hi = -1;
        lo = -1;
        err = 0;
        prev_char = 0;
        for (int i = MC - 1; i >= 0; i--) begin
            if (w[i*CW +: CW] != '0) begin
                if (hi < 0) hi = i;
                lo = i;
            end
        end
        c = (hi < 0) ? MC : MC - hi;
        repeat (c) lv.push_back(1'b1);
        if (hi < 0) begin
            repeat (wt) lv.push_back(1'b1);
        end else begin
            for (int i = hi; i >= lo; i--) begin
                c = int'(w[i*CW +: CW]);
                if (c == 0 || c > 36) begin
                    if (c > 36) err = 1;
                    repeat (wt) lv.push_back(1'b1);
                    prev_char = 0;
                end else begin
                    s = tbl[c];
                    if (prev_char) repeat (dah) lv.push_back(1'b1);
                    for (int j = 0; j < s.len(); j++) begin
                        if (j > 0) repeat (dit) lv.push_back(1'b1);
                        repeat ((s[j] == "-") ? dah : dit) lv.push_back(1'b0);
                    end
                    prev_char = 1;
                end
            end
            if (prev_char) repeat (wt) lv.push_back(1'b1);
        end
        nr = 0;
        run = 1;
        for (int k = 1; k <= lv.size(); k++) begin
            if (k < lv.size() && lv[k] == lv[k-1]) begin
                run++;
            end else begin
                exp_runs.push_back(run);
                nr++;
                run = 1;
            end
        end
        exp_nruns.push_back(nr);
        exp_err.push_back(err);
    endfunction

    // Monitor: collect line samples on ce-qualified cycles between busy rising and done.
    initial begin
        bit smp[$];
        int obs[$];
        bit act;
        int nr, r, run;
        bit e;
        act = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                act = 0;
                smp.delete();
            end else begin
                if (!act && busy) begin
                    act = 1;
                    smp.delete();
                    chk("error_clear_on_start", error, 0);
                end
                if (act) begin
                    if (done) begin
                        act = 0;
                        txn_seen++;
                        if (exp_nruns.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL unexpected_txn: got a transmission, expected none");
                        end else begin
                            nr = exp_nruns.pop_front();
                            e = exp_err.pop_front();
                            obs.delete();
                            run = 1;
                            for (int k = 1; k <= smp.size(); k++) begin
                                if (k < smp.size() && smp[k] == smp[k-1]) begin
                                    run++;
                                end else begin
                                    obs.push_back(run);
                                    run = 1;
                                end
                            end
                            chk($sformatf("txn%0d_run_count", txn_seen), obs.size(), nr);
                            for (int k = 0; k < nr; k++) begin
                                r = exp_runs.pop_front();
                                if (k < obs.size())
                                    chk($sformatf("txn%0d_run%0d", txn_seen, k), obs[k], r);
                            end
                            chk($sformatf("txn%0d_error", txn_seen), error, e);
                        end
                    end else if (ce) begin
                        smp.push_back(signal);
                    end
                end
            end
        end
    end

    task automatic send(input logic [CW*MC-1:0] w, input int dt, input int dh, input int wt, input bit expect_it);
        int k;
        @(posedge clk);
        #1;
        word      = w;
        dit_time  = PW'(dt);
        dah_time  = PW'(dh);
        word_time = PW'(wt);
        start     = 1'b1;
        if (expect_it) begin
            model(w, dt, dh, wt);
            n_issued++;
        end
        k = 0;
        while (!busy && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0;
        if (!busy) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: busy=%0d, expected 1", busy);
        end
        for (int i = 0; i < MC; i++) word[i*CW +: CW] = CW'($urandom_range(0, 63));
        dit_time  = PW'($urandom_range(0, 9));
        dah_time  = PW'($urandom_range(0, 9));
        word_time = PW'($urandom_range(0, 9));
    endtask

    task automatic wait_done(output int busy_cyc, output int low_cyc, input bit poke);
        bit seen;
        busy_cyc = 0;
        low_cyc  = 0;
        seen     = 0;
        for (int k = 0; k < 5000 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
            end else begin
                if (busy) busy_cyc++;
                if (!signal) low_cyc++;
            end
            if (poke) start = (k == 3) && busy;
        end
        start = 1'b0;
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: done never seen, expected a done pulse");
        end
    endtask

    initial begin
        int b, l, dt, dh, wt, r;
        bit got;
        logic [CW*MC-1:0] w;
        tbl = '{"", ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                "..-", "...-", ".--", "-..-", "-.--", "--..",
                "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."};
        n_chk = 0; n_fail = 0; n_issued = 0; txn_seen = 0; ce_toggle = 0;
        start = 1'b0; word = '0; dit_time = '0; dah_time = '0; word_time = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_signal", signal, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        send(mkw(5, 0, 0, 0, 0, 0), 2, 6, 14, 1);
        wait_done(b, l, 0);
        chk("E_busy_cycles", b, 17);
        chk("E_low_cycles", l, 2);

        send(mkw(0, 0, 0, 19, 15, 19), 2, 6, 14, 1);
        wait_done(b, l, 0);
        chk("SOS_low_cycles", l, 30);

        send(mkw(0, 0, 5, 0, 1, 20), 2, 6, 14, 1);
        wait_done(b, l, 0);

        send(mkw(0, 0, 0, 0, 0, 40), 0, 6, 14, 1);
        wait_done(b, l, 0);
        chk("unmapped_no_mark", l, 0);
        chk("unmapped_busy_cycles", b, 20);

        send(mkw(5, 0, 0, 0, 0, 0), 0, 6, 14, 1);
        wait_done(b, l, 0);
        chk("dit_zero_low_cycles", l, 1);

        ce_toggle = 1;
        send(mkw(20, 0, 0, 0, 0, 0), 2, 6, 14, 1);
        wait_done(b, l, 1);
        ce_toggle = 0;
        chk("T_ce_mark_clk_cycles", l, 12);

        send(mkw(40, 5, 0, 0, 0, 0), 2, 6, 14, 0);
        got = 0;
        for (int k = 0; k < 500 && !got; k++) begin
            @(negedge clk);
            if (!signal) got = 1;
        end
        chk("rst_reached_mark", got, 1);
        chk("rst_pre_error", error, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_signal", signal, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_error", error, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        send(mkw(0, 0, 0, 0, 1, 27), 1, 3, 7, 1);
        wait_done(b, l, 0);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < MC; i++) begin
                r = $urandom_range(0, 9);
                if (r < 4)       w[i*CW +: CW] = '0;
                else if (r == 9) w[i*CW +: CW] = CW'($urandom_range(37, 63));
                else             w[i*CW +: CW] = CW'($urandom_range(1, 36));
            end
            dt = $urandom_range(0, 3);
            dh = $urandom_range(0, 7);
            wt = $urandom_range(0, 10);
            ce_toggle = ($urandom_range(0, 3) == 0);
            send(w, dt, dh, wt, 1);
            wait_done(b, l, $urandom_range(0, 1) == 1);
            ce_toggle = 0;
        end

        repeat (20) @(negedge clk);
        chk("queue_drained", exp_nruns.size(), 0);
        chk("txn_count", txn_seen, n_issued);
        chk("final_idle_busy", busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
